// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port between the ALU writeback path
// and the load (memory) writeback path. Each source owns a one-entry holding
// buffer behind a valid/ready handshake; a round-robin arbiter picks one full
// buffer per cycle and drives a registered write port into the register file.
// It also flags read-after-write hazards for two read addresses and counts
// cycles in which both buffers were full.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   alu_valid/alu_ready/addr/data    ALU writeback request channel
//   mem_valid/mem_ready/addr/data    load writeback request channel
//   rf_write_enable/addr, rf_data    registered register-file write port
//   rd_addr_a/b, hazard_a/b          read-after-write hazard query
//   conflict_count                   saturating count of both-full cycles
module regfile_wb_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [4:0]       alu_addr,
  input  logic [31:0]      alu_data,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [4:0]       mem_addr,
  input  logic [31:0]      mem_data,
  output logic             rf_write_enable,
  output logic [4:0]       rf_write_addr,
  output logic [31:0]      rf_data,
  input  logic [4:0]       rd_addr_a,
  input  logic [4:0]       rd_addr_b,
  output logic             hazard_a,
  output logic             hazard_b,
  output logic [CNT_W-1:0] conflict_count
);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  logic             alu_full_q, alu_full_d;
  logic [4:0]       alu_addr_q, alu_addr_d;
  logic [31:0]      alu_data_q, alu_data_d;
  logic             mem_full_q, mem_full_d;
  logic [4:0]       mem_addr_q, mem_addr_d;
  logic [31:0]      mem_data_q, mem_data_d;
  src_e             last_grant_q, last_grant_d;
  logic             we_q, we_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic alu_grant_s, mem_grant_s;
  logic alu_hs_s, mem_hs_s;
  logic both_full_s;

  // A read address hits if any write not yet visible in the register file
  // targets it; x0 never hazards since it is never written.
  function automatic logic raw_hit(
    input logic [4:0] rd,
    input logic       a_full, input logic [4:0] a_addr,
    input logic       m_full, input logic [4:0] m_addr,
    input logic       w_en,   input logic [4:0] w_addr
  );
    logic hit;
    hit = (a_full && (a_addr == rd)) ||
          (m_full && (m_addr == rd)) ||
          (w_en   && (w_addr == rd));
    return (rd != 5'd0) && hit;
  endfunction

  assign both_full_s = alu_full_q && mem_full_q;

  // Round-robin grant from buffer state only; on a conflict the source that
  // did not win last time is served.
  always_comb begin
    alu_grant_s = 1'b0;
    mem_grant_s = 1'b0;
    if (both_full_s) begin
      if (last_grant_q == SRC_MEM) begin
        alu_grant_s = 1'b1;
      end else begin
        mem_grant_s = 1'b1;
      end
    end else if (alu_full_q) begin
      alu_grant_s = 1'b1;
    end else if (mem_full_q) begin
      mem_grant_s = 1'b1;
    end else begin
      alu_grant_s = 1'b0;
      mem_grant_s = 1'b0;
    end
  end

  // A buffer being drained this cycle can accept a new entry on the same edge.
  assign alu_ready = !alu_full_q || alu_grant_s;
  assign mem_ready = !mem_full_q || mem_grant_s;
  assign alu_hs_s  = alu_valid && alu_ready;
  assign mem_hs_s  = mem_valid && mem_ready;

  // Next state: buffers (load beats clear, x0 writes dropped), pointer,
  // output register and saturating conflict counter.
  always_comb begin
    alu_full_d   = alu_full_q;
    alu_addr_d   = alu_addr_q;
    alu_data_d   = alu_data_q;
    mem_full_d   = mem_full_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    last_grant_d = last_grant_q;
    we_d         = alu_grant_s || mem_grant_s;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;

    if (alu_hs_s) begin
      alu_full_d = (alu_addr != 5'd0);
      alu_addr_d = alu_addr;
      alu_data_d = alu_data;
    end else if (alu_grant_s) begin
      alu_full_d = 1'b0;
    end else begin
      alu_full_d = alu_full_q;
    end

    if (mem_hs_s) begin
      mem_full_d = (mem_addr != 5'd0);
      mem_addr_d = mem_addr;
      mem_data_d = mem_data;
    end else if (mem_grant_s) begin
      mem_full_d = 1'b0;
    end else begin
      mem_full_d = mem_full_q;
    end

    // The pointer only moves when it actually decided something.
    if (both_full_s) begin
      last_grant_d = alu_grant_s ? SRC_ALU : SRC_MEM;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      last_grant_d = last_grant_q;
    end

    if (alu_grant_s) begin
      waddr_d = alu_addr_q;
      wdata_d = alu_data_q;
    end else if (mem_grant_s) begin
      waddr_d = mem_addr_q;
      wdata_d = mem_data_q;
    end else begin
      waddr_d = waddr_q;
      wdata_d = wdata_q;
    end
  end

  // State registers; reset empties buffers and points at MEM so the ALU wins
  // the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_full_q   <= 1'b0;
      alu_addr_q   <= 5'd0;
      alu_data_q   <= 32'd0;
      mem_full_q   <= 1'b0;
      mem_addr_q   <= 5'd0;
      mem_data_q   <= 32'd0;
      last_grant_q <= SRC_MEM;
      we_q         <= 1'b0;
      waddr_q      <= 5'd0;
      wdata_q      <= 32'd0;
      cnt_q        <= {CNT_W{1'b0}};
    end else begin
      alu_full_q   <= alu_full_d;
      alu_addr_q   <= alu_addr_d;
      alu_data_q   <= alu_data_d;
      mem_full_q   <= mem_full_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
    end
  end

  assign rf_write_enable = we_q;
  assign rf_write_addr   = waddr_q;
  assign rf_data         = wdata_q;
  assign conflict_count  = cnt_q;

  // The rf_write term covers the cycle where the register file still returns
  // the old value for a read issued alongside the write.
  assign hazard_a = raw_hit(rd_addr_a, alu_full_q, alu_addr_q,
                            mem_full_q, mem_addr_q, we_q, waddr_q);
  assign hazard_b = raw_hit(rd_addr_b, alu_full_q, alu_addr_q,
                            mem_full_q, mem_addr_q, we_q, waddr_q);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             alu_valid = 1'b0, mem_valid = 1'b0;
  logic             alu_ready, mem_ready;
  logic [4:0]       alu_addr = 5'd0, mem_addr = 5'd0;
  logic [31:0]      alu_data = 32'd0, mem_data = 32'd0;
  logic             rf_write_enable;
  logic [4:0]       rf_write_addr;
  logic [31:0]      rf_data;
  logic [4:0]       rd_addr_a = 5'd0, rd_addr_b = 5'd0;
  logic             hazard_a, hazard_b;
  logic [CNT_W-1:0] conflict_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  regfile_wb_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr), .rf_data(rf_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .hazard_a(hazard_a), .hazard_b(hazard_b),
    .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  // Model: pending writes per source (0 = ALU, 1 = MEM), who wins the next
  // tie, the write currently presented to the register file, and the count.
  logic        m_full [2];
  logic [4:0]  m_addr [2];
  logic [31:0] m_data [2];
  int          m_favour;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_full[s] = 1'b0; m_addr[s] = 5'd0; m_data[s] = 32'd0;
    end
    m_favour = 0; m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0; m_cnt = 0;
  endtask

  function automatic int winner();
    if (m_full[0] && m_full[1]) return m_favour;
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  function automatic logic m_hazard(input logic [4:0] r);
    logic h;
    h = 1'b0;
    if (r == 5'd0) return 1'b0;
    for (int s = 0; s < 2; s++) if (m_full[s] && m_addr[s] == r) h = 1'b1;
    if (m_we && m_waddr == r) h = 1'b1;
    return h;
  endfunction

  // One clock: sample inputs mid-cycle, advance the model at the rising edge.
  task automatic cycle();
    int w;
    logic v [2];
    logic [4:0] a [2];
    logic [31:0] d [2];
    logic rdy;
    @(negedge clk);
    w = winner();
    v[0] = alu_valid; a[0] = alu_addr; d[0] = alu_data;
    v[1] = mem_valid; a[1] = mem_addr; d[1] = mem_data;
    @(posedge clk);
    if (m_full[0] && m_full[1]) begin
      m_favour = 1 - w;
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    m_we = (w >= 0);
    if (w >= 0) begin
      m_waddr = m_addr[w];
      m_wdata = m_data[w];
    end
    for (int s = 0; s < 2; s++) begin
      rdy = !m_full[s] || (w == s);
      if (w == s) m_full[s] = 1'b0;
      if (v[s] && rdy) begin
        m_full[s] = (a[s] != 5'd0);
        m_addr[s] = a[s];
        m_data[s] = d[s];
      end
    end
    #1;
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      int w;
      w = winner();
      check("alu_ready", 64'(alu_ready), 64'(!m_full[0] || w == 0));
      check("mem_ready", 64'(mem_ready), 64'(!m_full[1] || w == 1));
      check("rf_we",     64'(rf_write_enable), 64'(m_we));
      check("rf_addr",   64'(rf_write_addr), 64'(m_waddr));
      check("rf_data",   64'(rf_data), 64'(m_wdata));
      check("hazard_a",  64'(hazard_a), 64'(m_hazard(rd_addr_a)));
      check("hazard_b",  64'(hazard_b), 64'(m_hazard(rd_addr_b)));
      check("conflict_count", 64'(conflict_count), 64'(m_cnt));
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_we",   64'(rf_write_enable), 64'd0);
    check("rst_addr", 64'(rf_write_addr), 64'd0);
    check("rst_data", 64'(rf_data), 64'd0);
    check("rst_cnt",  64'(conflict_count), 64'd0);
    check("rst_ready", 64'({alu_ready, mem_ready}), 64'd3);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Single ALU write: visible two edges after the handshake, for one cycle.
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    cycle();
    alu_valid = 1'b0;
    cycle();
    check("t1_we",   64'(rf_write_enable), 64'd1);
    check("t1_addr", 64'(rf_write_addr), 64'd5);
    check("t1_data", 64'(rf_data), 64'hDEADBEEF);
    cycle();
    check("t1_we_off", 64'(rf_write_enable), 64'd0);
    check("t1_cnt",    64'(conflict_count), 64'd0);

    // Simultaneous requests: ALU first, MEM next.
    rd_addr_b = 5'd4;
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h11;
    mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'h22;
    cycle();
    alu_valid = 1'b0; mem_valid = 1'b0;
    cycle();
    check("t2_first_addr", 64'(rf_write_addr), 64'd3);
    check("t2_first_data", 64'(rf_data), 64'h11);
    cycle();
    check("t2_second_addr", 64'(rf_write_addr), 64'd4);
    check("t2_second_data", 64'(rf_data), 64'h22);
    check("t2_cnt", 64'(conflict_count), 64'd1);
    cycle();

    // Continuous contention; ALU won the last tie, so MEM goes first here.
    for (int i = 0; i < 8; i++) begin
      alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'h100 + 32'(i);
      mem_valid = 1'b1; mem_addr = 5'd20; mem_data = 32'h200 + 32'(i);
      cycle();
      if (i == 1) check("t3_mem_first", 64'(rf_data), 64'h200);
      if (i == 2) check("t3_alu_second", 64'(rf_data), 64'h100);
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    check("t3_cnt_sat", 64'(conflict_count), 64'(CNT_MAX));
    repeat (4) cycle();
    check("t3_cnt_hold", 64'(conflict_count), 64'(CNT_MAX));

    // x0 write is accepted and dropped.
    rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'hFFFFFFFF;
    #1;
    check("t4_ready", 64'(mem_ready), 64'd1);
    check("t4_haz",   64'(hazard_a), 64'd0);
    cycle();
    mem_valid = 1'b0;
    cycle();
    check("t4_no_we", 64'(rf_write_enable), 64'd0);
    cycle();
    check("t4_no_we2", 64'(rf_write_enable), 64'd0);

    // Hazard window around a write to r7.
    rd_addr_a = 5'd7;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h77;
    #1;
    check("t5_haz_incoming", 64'(hazard_a), 64'd0);
    cycle();
    alu_valid = 1'b0;
    check("t5_haz_buf", 64'(hazard_a), 64'd1);
    cycle();
    check("t5_haz_out", 64'(hazard_a), 64'd1);
    cycle();
    check("t5_haz_clear", 64'(hazard_a), 64'd0);

    // Async reset while both buffers are full and a write is on the port.
    rd_addr_a = 5'd9;
    alu_valid = 1'b1; alu_addr = 5'd9;  alu_data = 32'h99;
    mem_valid = 1'b1; mem_addr = 5'd12; mem_data = 32'hCC;
    cycle();
    cycle();
    alu_valid = 1'b0; mem_valid = 1'b0;
    check("t6_pre_we", 64'(rf_write_enable), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_we",   64'(rf_write_enable), 64'd0);
    check("t6_addr", 64'(rf_write_addr), 64'd0);
    check("t6_data", 64'(rf_data), 64'd0);
    check("t6_cnt",  64'(conflict_count), 64'd0);
    check("t6_haz",  64'(hazard_a), 64'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
    cycle();
    cycle();
    check("t6_no_write", 64'(rf_write_enable), 64'd0);
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'hA1;
    mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'hB2;
    cycle();
    alu_valid = 1'b0; mem_valid = 1'b0;
    cycle();
    check("t6_alu_wins_addr", 64'(rf_write_addr), 64'd1);
    check("t6_alu_wins_data", 64'(rf_data), 64'hA1);
    cycle();
    check("t6_mem_next", 64'(rf_write_addr), 64'd2);
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback sources: ALU results and load data returning from memory.
- Each source has a valid/ready handshake and a 1-entry holding buffer.
- Round-robin arbitration drives registered write_enable, write_addr and data into the register file.
- Also reports read-after-write hazards for the two register-file read addresses, plus a saturating conflict counter.

Parameters:
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted this cycle when alu_valid is also high.
- alu_addr  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- mem_valid  in  1  load writeback request.
- mem_ready  out  1  load request accepted this cycle when mem_valid is also high.
- mem_addr  in  5  load destination register.
- mem_data  in  32  load data.
- rf_write_enable  out  1  register-file write enable (registered).
- rf_write_addr  out  5  register-file write address (registered).
- rf_data  out  32  register-file write data (registered).
- rd_addr_a  in  5  register-file read address A (query only).
- rd_addr_b  in  5  register-file read address B (query only).
- hazard_a  out  1  a pending write targets rd_addr_a.
- hazard_b  out  1  a pending write targets rd_addr_b.
- conflict_count  out  CNT_W  number of cycles both buffers were full.

Behaviour:
- Reset (async, rst_n=0):
  - both buffers empty; rf_write_enable=0, rf_write_addr=0, rf_data=0.
  - conflict_count=0.
  - last-grant pointer=MEM, so the ALU wins the first conflict.
  - Reset mid-operation discards buffered writes; no write is issued after reset deasserts until new requests arrive.
- Buffers: one entry per source, {full, addr, data}.
  - Handshake = valid & ready, sampled at the rising edge.
  - On handshake with addr!=0, the buffer loads and is full from the next cycle.
  - On handshake with addr==0, the request is accepted and dropped; the buffer stays empty and no write is issued.
- ready (combinational, no dependence on valid): x_ready = !x_full | x_grant.
  - Each source sustains one write per cycle when uncontested.
- Grant (combinational from buffer state only):
  - only ALU full -> ALU; only MEM full -> MEM.
  - both full -> the source not equal to the last-grant pointer; pointer updates to the granted source.
  - The granted buffer clears at the edge.
  - A same-edge handshake on the granted source refills that buffer (load wins over clear).
- Output register, updated at every edge:
  - rf_write_enable <= any grant.
  - rf_write_addr/rf_data <= the granted buffer's addr/data.
  - With no grant: rf_write_enable <= 0; addr/data hold their previous values.
- Latency: handshake at edge E0 -> grant in the following cycle -> rf_write_enable=1 in the cycle after edge E1 -> register file commits at E2.
  - Uncontested: 2 cycles handshake-to-commit.
  - Contested loser: +1 cycle per lost arbitration.
  - Round-robin bounds the wait to 1 extra cycle.
- Hazards (combinational), for x in {a, b}:
  - hazard_x = (rd_addr_x!=0) & ( (alu_full & alu_addr==rd_addr_x) | (mem_full & mem_addr==rd_addr_x) | (rf_write_enable & rf_write_addr==rd_addr_x) ).
  - The rf_write term exists because a read issued on the same edge as a write returns the old value.
  - Incoming (not yet accepted) requests are not included.
- Same destination in both buffers: both writes issue in grant order. Write ordering between sources is the issuing pipeline's responsibility; it must use hazard_x to stall.
- conflict_count increments on every cycle with alu_full & mem_full, and saturates at all-ones.
- Only the low 4 address bits are consumed downstream. The arbiter still compares all 5 bits and passes all 5 bits through.

Test Plan:
- Reset then single ALU write: alu_valid=1, addr=5, data=0xDEADBEEF for 1 cycle -> rf_write_enable=1, addr=5, data=0xDEADBEEF exactly 2 cycles after handshake, for 1 cycle; conflict_count=0.
- Simultaneous requests: ALU (3, 0x11) and MEM (4, 0x22) accepted at the same edge -> ALU write appears first, MEM the next cycle; conflict_count=1.
- Continuous contention: both sources valid every cycle for 8 cycles with incrementing data -> writes alternate ALU/MEM; each ready is low at most 1 cycle in 2; conflict_count saturates correctly with CNT_W=2.
- x0 drop: mem_valid with addr=0, data=0xFFFFFFFF -> mem_ready=1, no rf_write_enable, hazard_a=0 with rd_addr_a=0.
- Hazard window: ALU write to r7 accepted, rd_addr_a=7 -> hazard_a=1 in both the buffered and the output-register cycles, 0 the cycle after commit.
- Async reset mid-operation: rst_n low for a partial cycle while both buffers are full -> all outputs 0 immediately; no write issued after release; the first conflict after reset is granted to the ALU.
